scan_decoder: RTL and testbench
===============================

# scan_decoder

Parametrised, registered SEL_W-to-2^SEL_W one-hot decoder with a valid/ready select input and an autonomous scan mode. In scan mode an internal counter walks the one-hot output across every line, holding each line for a programmable dwell. It is the sequential successor to the team's fixed 3-to-8 gate-level decoder. It drives row/digit strobes and chip-selects where either host-selected or time-multiplexed activation is needed.

## Interface
- SEL_W, 3, select width; output count OUT_N = 2**SEL_W (derived localparam, SEL_W >= 1)
- DWELL, 4, cycles each line is held in scan mode (DWELL >= 1)
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- en  in  1  block enable; low forces outputs off and freezes scan
- mode  in  1  0 = DIRECT, 1 = SCAN
- sel_valid  in  1  select transfer request (DIRECT only)
- sel  in  SEL_W  line index to activate
- sel_ready  out  1  = en && !rst && state==DIRECT && mode==0 (combinational)
- dout  out  OUT_N  registered one-hot (or all-zero) decoder output
- idx  out  SEL_W  registered index of the currently scanned line
- wrap  out  1  registered one-cycle pulse on scan wrap-around

## Operation
- One clock and one synchronous active-high reset, both as named above.
- Reset values: state DIRECT, dout 0, idx 0, dwell counter 0, wrap 0. sel_ready is 0 while rst is high.
- FSM states:
  - DIRECT -> SCAN on an edge with en=1, mode=1.
  - SCAN -> DIRECT on an edge with en=1, mode=0.
  - With en=0, the state holds.
- DIRECT behaviour:
  - On a transfer (sel_valid && sel_ready), dout <= 1<<sel at the next edge.
  - Without a transfer, dout holds its last value. Any sel value is legal; there is no out-of-range case.
- Entering SCAN: dout <= 1<<0, idx <= 0, dwell counter <= 0. No wrap pulse on entry.
- SCAN behaviour:
  - The dwell counter increments each en=1 cycle.
  - At DWELL-1 the counter clears and idx advances.
  - idx wraps from OUT_N-1 to 0, and wrap=1 is registered with that same edge.
  - dout always equals 1<<idx.
- Leaving SCAN: dout <= 0, idx <= 0, counter <= 0.
- en=0:
  - dout <= 0 at the next edge.
  - idx, dwell counter and state are frozen; wrap <= 0.
  - On en returning high in SCAN, dout <= 1<<idx at the next edge and dwell resumes from the frozen count.
  - On en returning high in DIRECT, dout stays 0 until the next transfer.
- Simultaneous events:
  - mode=1 with sel_valid=1: sel_ready=0, so no transfer happens and the SCAN entry wins.
  - rst overrides en and mode.
  - rst mid-scan returns to the reset values at the next edge.

## Timing
- DIRECT latency: 1 cycle from the accepting edge to dout.
- SCAN:
  - Each line is high for exactly DWELL consecutive cycles (en held high).
  - Full sweep period is OUT_N*DWELL cycles.
  - wrap is high for 1 cycle, coincident with the first cycle that dout returns to bit 0.
- Mode switch: effective at the first edge after mode changes (en=1).
- sel_ready has no registered delay. Throughput is one transfer per cycle in DIRECT.

## Structure
- Package scan_decoder_pkg holds:
  - enum dec_state_t {ST_DIRECT, ST_SCAN}
  - constants MODE_DIRECT=0 and MODE_SCAN=1
  - function onehot_f(idx, width)
- One sub-module, onehot_dec (parametrised combinational SEL_W->OUT_N decoder). It is instantiated once and feeds the dout register from a mux of sel and idx.
- Dwell counter width is max(1, $clog2(DWELL)).

## Test plan
(SEL_W=3, DWELL=2 unless stated.)
- Reset: rst=1 for 2 cycles -> dout=8'h00, idx=0, wrap=0, sel_ready=0. After release, sel_ready=1.
- DIRECT sweep: sel=0..7 with sel_valid=1 -> dout=8'h01..8'h80, each one cycle after acceptance. Then sel_valid=0 for 5 cycles -> dout holds 8'h80.
- SCAN: mode=1 -> dout sequence 01,01,02,02,...,80,80,01. wrap=1 only on the 17th cycle after entry; period 16.
- en pause: en=0 for 3 cycles while idx=3 after 1 dwell cycle -> dout=00 and idx=3 during the pause. After en=1 -> dout=08 for 1 cycle, then 10.
- Reset mid-scan: rst=1 at idx=5 -> next edge dout=00, idx=0, wrap=0, state DIRECT.
- Mode collision: mode=1 and sel_valid=1 with sel=6 in the same cycle -> sel_ready=0, dout=01 next cycle. Then mode=0 -> dout=00, sel_ready=1.

Source files
------------

// File: rtl/scan_decoder_pkg.sv
// Shared types and helpers for the scan_decoder block: FSM state encoding,
// mode constants and a width-limited one-hot helper.
package scan_decoder_pkg;

   typedef enum logic {
      ST_DIRECT = 1'b0,
      ST_SCAN   = 1'b1
   } dec_state_t;

   localparam logic MODE_DIRECT = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;

   // Upper bound on the decoded width the helper can return; callers cast down.
   localparam int ONEHOT_MAX_W = 1024;

   function automatic logic [ONEHOT_MAX_W-1:0] onehot_f(input int idx, input int width);
      if (idx < 0 || idx >= width || idx >= ONEHOT_MAX_W)
         onehot_f = '0;
      else
         onehot_f = ONEHOT_MAX_W'(1) << idx;
   endfunction

endpackage

// File: rtl/scan_decoder_if.sv
// Bus bundle between a host and scan_decoder: control inputs, the select
// handshake and the registered decoder outputs.
interface scan_decoder_if #(
   parameter int SEL_W = 3
);
   localparam int OUT_N = 2 ** SEL_W;

   logic             en;
   logic             mode;
   // Handshake: a select transfers on a rising edge where sel_valid and
   // sel_ready are both high; sel must be stable while sel_valid is high,
   // and sel_ready never depends on sel_valid.
   logic             sel_valid;
   logic [SEL_W-1:0] sel;
   logic             sel_ready;
   logic [OUT_N-1:0] dout;
   logic [SEL_W-1:0] idx;
   logic             wrap;

   modport master (
      output en, mode, sel_valid, sel,
      input  sel_ready, dout, idx, wrap
   );

   modport slave (
      input  en, mode, sel_valid, sel,
      output sel_ready, dout, idx, wrap
   );

endinterface

// File: rtl/scan_decoder_onehot_dec.sv
// Combinational SEL_W -> 2**SEL_W one-hot decoder; every select value maps
// to exactly one asserted line.
module onehot_dec
   import scan_decoder_pkg::*;
#(
   parameter int SEL_W = 3,
   localparam int OUT_N = 2 ** SEL_W
) (
   input  logic [SEL_W-1:0] sel,
   output logic [OUT_N-1:0] dout
);

   assign dout = OUT_N'(onehot_f(int'(sel), OUT_N));

endmodule

// File: rtl/scan_decoder.sv
// Registered one-hot decoder with a host-driven DIRECT mode and an autonomous
// SCAN mode that walks the active line, holding each for DWELL cycles.
module scan_decoder
   import scan_decoder_pkg::*;
#(
   parameter int SEL_W = 3,
   parameter int DWELL = 4
) (
   input  logic          clk,
   input  logic          rst,
   scan_decoder_if.slave bus,
   output dec_state_t    dbg_state
);

   localparam int OUT_N = 2 ** SEL_W;
   localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
   localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(OUT_N - 1);

   dec_state_t       state_q, state_d;
   logic [OUT_N-1:0] dout_q, dout_d;
   logic [SEL_W-1:0] idx_q, idx_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             wrap_q, wrap_d;

   logic             sel_ready;
   logic             transfer;
   logic [SEL_W-1:0] dec_sel;
   logic [OUT_N-1:0] dec_out;

   assign sel_ready = bus.en && !rst && (state_q == ST_DIRECT) && (bus.mode == MODE_DIRECT);
   assign transfer  = bus.sel_valid && sel_ready;

   always_comb begin
      state_d = state_q;
      if (bus.en) begin
         case (state_q)
            ST_DIRECT: if (bus.mode == MODE_SCAN)   state_d = ST_SCAN;
            ST_SCAN:   if (bus.mode == MODE_DIRECT) state_d = ST_DIRECT;
            default:   state_d = ST_DIRECT;
         endcase
      end
   end

   // Any mode change restarts the sweep; with en low everything is frozen.
   always_comb begin
      idx_d  = idx_q;
      cnt_d  = cnt_q;
      wrap_d = 1'b0;
      if (bus.en) begin
         if (state_d != state_q) begin
            idx_d = '0;
            cnt_d = '0;
         end else if (state_q == ST_SCAN) begin
            if (cnt_q == CNT_LAST) begin
               cnt_d  = '0;
               idx_d  = idx_q + SEL_W'(1);
               wrap_d = (idx_q == IDX_LAST);
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
      end
   end

   // The single decoder serves both the host select and the scan position.
   assign dec_sel = (state_d == ST_SCAN) ? idx_d : bus.sel;

   onehot_dec #(
      .SEL_W (SEL_W)
   ) u_dec (
      .sel  (dec_sel),
      .dout (dec_out)
   );

   always_comb begin
      dout_d = dout_q;
      if (!bus.en)
         dout_d = '0;
      else if (state_d == ST_SCAN)
         dout_d = dec_out;
      else if (state_q == ST_SCAN)
         dout_d = '0;
      else if (transfer)
         dout_d = dec_out;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_DIRECT;
         dout_q  <= '0;
         idx_q   <= '0;
         cnt_q   <= '0;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         dout_q  <= dout_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         wrap_q  <= wrap_d;
      end
   end

   assign bus.sel_ready = sel_ready;
   assign bus.dout      = dout_q;
   assign bus.idx       = idx_q;
   assign bus.wrap      = wrap_q;
   assign dbg_state     = state_q;

endmodule

// File: tb/tb_scan_decoder.sv
// Self-checking bench for scan_decoder: directed scenarios followed by random
// traffic, checked against a sweep-position model through an expected queue.
module tb_scan_decoder;
   import scan_decoder_pkg::*;

   localparam int SEL_W  = 3;
   localparam int DWELL  = 2;
   localparam int OUT_N  = 2 ** SEL_W;
   localparam int PERIOD = OUT_N * DWELL;
   localparam int EW     = 2 + SEL_W + OUT_N;

   logic clk = 1'b0;
   logic rst = 1'b1;

   scan_decoder_if #(.SEL_W(SEL_W)) bus ();
   dec_state_t dbg_state;

   scan_decoder #(
      .SEL_W (SEL_W),
      .DWELL (DWELL)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   logic [EW-1:0] exp_q[$];

   // Model: in scan, position = enabled cycles since entry; line and wrap
   // follow from division by the dwell and the full sweep period.
   bit               m_scan = 1'b0;
   int               m_pos  = 0;
   logic [OUT_N-1:0] m_held = '0;

   function automatic logic [EW-1:0] pack_exp(bit st, bit w, int line, logic [OUT_N-1:0] d);
      return {st, w, SEL_W'(line), d};
   endfunction

   task automatic step(input bit r, input bit e, input bit m, input bit v, input int s);
      bit               exp_ready;
      bit               w;
      int               line;
      logic [OUT_N-1:0] d;
      @(negedge clk);
      rst           = r;
      bus.en        = e;
      bus.mode      = m;
      bus.sel_valid = v;
      bus.sel       = SEL_W'(s);
      #1;
      exp_ready = e && !r && !m_scan && !m;
      checks++;
      if (bus.sel_ready !== exp_ready) begin
         failures++;
         $display("FAIL sel_ready t=%0t actual=%b expected=%b", $time, bus.sel_ready, exp_ready);
      end
      w = 1'b0;
      if (r) begin
         m_scan = 1'b0;
         m_pos  = 0;
         m_held = '0;
      end else if (!e) begin
         m_held = '0;
      end else if (!m_scan && m) begin
         m_scan = 1'b1;
         m_pos  = 0;
      end else if (m_scan && !m) begin
         m_scan = 1'b0;
         m_pos  = 0;
         m_held = '0;
      end else if (m_scan) begin
         m_pos++;
         w = ((m_pos % PERIOD) == 0);
      end else if (v) begin
         m_held = OUT_N'(1) << s;
      end
      line = m_scan ? (m_pos / DWELL) % OUT_N : 0;
      if (!m_scan)
         d = m_held;
      else if (e && !r)
         d = OUT_N'(1) << line;
      else
         d = '0;
      exp_q.push_back(pack_exp(m_scan, w, line, d));
   endtask

   always @(posedge clk) begin
      logic [EW-1:0] exp_w;
      logic [EW-1:0] act_w;
      #1;
      if (exp_q.size() != 0) begin
         exp_w = exp_q.pop_front();
         act_w = {dbg_state == ST_SCAN, bus.wrap, bus.idx, bus.dout};
         checks++;
         if (act_w !== exp_w) begin
            failures++;
            $display("FAIL outputs t=%0t actual scan=%b wrap=%b idx=%0d dout=%h expected scan=%b wrap=%b idx=%0d dout=%h",
                     $time, act_w[EW-1], act_w[EW-2], act_w[OUT_N +: SEL_W], act_w[OUT_N-1:0],
                     exp_w[EW-1], exp_w[EW-2], exp_w[OUT_N +: SEL_W], exp_w[OUT_N-1:0]);
         end
      end
   end

   initial begin
      int  guard;
      bit  cur_mode;
      bus.en        = 1'b1;
      bus.mode      = 1'b0;
      bus.sel_valid = 1'b0;
      bus.sel       = '0;

      // Reset, then release.
      step(1, 1, 0, 0, 0);
      step(1, 1, 0, 0, 0);
      step(0, 1, 0, 0, 0);

      // DIRECT sweep, then hold.
      for (int s = 0; s < OUT_N; s++) step(0, 1, 0, 1, s);
      repeat (5) step(0, 1, 0, 0, 0);

      // SCAN entry through one full wrap.
      repeat (PERIOD + 2) step(0, 1, 1, 0, 0);

      // Run to the first dwell cycle of line 3, then pause.
      guard = 0;
      while (!(((m_pos / DWELL) % OUT_N) == 3 && (m_pos % DWELL) == 0) && guard < 100) begin
         step(0, 1, 1, 0, 0);
         guard++;
      end
      repeat (3) step(0, 0, 1, 0, 0);

      // Resume and reset mid-scan at line 5.
      guard = 0;
      while (((m_pos / DWELL) % OUT_N) != 5 && guard < 100) begin
         step(0, 1, 1, 0, 0);
         guard++;
      end
      step(1, 1, 1, 0, 0);
      step(0, 1, 0, 0, 0);

      // Mode collision: scan entry wins over a pending select.
      step(0, 1, 1, 1, 6);
      step(0, 1, 0, 0, 0);
      step(0, 1, 0, 1, 2);
      step(0, 0, 0, 1, 4);
      step(0, 1, 0, 0, 0);

      // Random traffic.
      cur_mode = 1'b0;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 19) == 0) cur_mode = ~cur_mode;
         step($urandom_range(0, 59) == 0, $urandom_range(0, 7) != 0, cur_mode,
              $urandom_range(0, 1) == 1, int'($urandom_range(0, OUT_N - 1)));
      end

      repeat (3) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain actual=%0d pending expected=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
